// File: rtl/adder32_arbiter.sv
// +-----------------------------------------------------------------------------
// | Module      : adder32_arbiter (with leaf fulladder32)
// | Description : One shared 32-bit adder arbitrated between N_REQ requesters,
// |               registered tagged result, locked multi-word carry chaining.
// |               Define ADDER32_ARB_RR_EN for round-robin, else fixed priority.
// | Revision    : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module fulladder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Pin,
  output logic [31:0] S,
  output logic        Pout
);
  assign {Pout, S} = {1'b0, A} + {1'b0, B} + {32'b0, Pin};
endmodule

module adder32_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_cin,
  input  logic [N_REQ-1:0]     req_lock,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_sum,
  output logic                 res_cout,
  output logic [IDW-1:0]       res_id,
  output logic                 locked
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic [IDW-1:0] r_owner;
  logic           r_saved_carry;
  logic           r_res_valid;
  logic [31:0]    r_res_sum;
  logic           r_res_cout;
  logic [IDW-1:0] r_res_id;

  logic [IDW-1:0] w_rr_ptr;
  logic           w_grant_vld;
  logic [IDW-1:0] w_grant_idx;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_can_accept;
  logic           w_xfer;
  logic           w_lock_beat;
  logic [31:0]    w_a;
  logic [31:0]    w_b;
  logic           w_pin;
  logic [31:0]    w_s;
  logic           w_pout;

  assign w_can_accept = !r_res_valid || res_ready;
  assign w_xfer       = w_grant_vld && w_can_accept;
  assign w_lock_beat  = req_lock[w_grant_idx];
  assign w_ptr_nxt    = (w_grant_idx == IDW'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

`ifdef ADDER32_ARB_RR_EN
  logic [IDW-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  assign w_rr_ptr = '0;
`endif

  // Descending scan: the last hit written is the nearest requester at/after the pointer.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (r_state == ST_LOCKED) begin
      w_grant_vld = req_valid[r_owner];
      w_grant_idx = r_owner;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(w_rr_ptr) + k) % N_REQ]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = IDW'((int'(w_rr_ptr) + k) % N_REQ);
        end
      end
    end
  end

  assign w_a   = req_a[32*w_grant_idx +: 32];
  assign w_b   = req_b[32*w_grant_idx +: 32];
  assign w_pin = (r_state == ST_LOCKED) ? r_saved_carry : req_cin[w_grant_idx];

  fulladder32 u_add (
    .A    (w_a),
    .B    (w_b),
    .Pin  (w_pin),
    .S    (w_s),
    .Pout (w_pout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = w_lock_beat ? ST_LOCKED : ST_ARB;
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_grant_idx] = 1'b1;
    end
    locked = (r_state == ST_LOCKED);
  end

  // Owner and carry only matter while a lock is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner       <= '0;
      r_saved_carry <= 1'b0;
    end else if (w_xfer && w_lock_beat) begin
      r_owner       <= w_grant_idx;
      r_saved_carry <= w_pout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_id    <= '0;
    end else if (w_xfer) begin
      r_res_valid <= 1'b1;
      r_res_sum   <= w_s;
      r_res_cout  <= w_pout;
      r_res_id    <= w_grant_idx;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_cout  = r_res_cout;
  assign res_id    = r_res_id;

endmodule

`default_nettype wire

// File: tb/tb_adder32_arbiter.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_adder32_arbiter
// | Description : Randomised and directed bench with arithmetic reference model.
// | Revision    : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_adder32_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef ADDER32_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_cin, req_lock;
  logic [32*N-1:0] req_a, req_b;
  logic            res_valid, res_ready, res_cout, locked;
  logic [31:0]     res_sum;
  logic [IDW-1:0]  res_id;

  int checks = 0;
  int errors = 0;

  logic [IDW+32:0] q[$];

  always #5 clk = ~clk;

  adder32_arbiter #(.N_REQ(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_lock  (req_lock),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .locked    (locked)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who may transfer this cycle, and what the result must be.
  bit          m_locked = 1'b0;
  bit          m_resv   = 1'b0;
  bit          m_carry  = 1'b0;
  int          m_owner  = 0;
  int          m_ptr    = 0;
  int          g;
  bit          can;
  logic        cin_m;
  logic [32:0] sum_m;
  logic [N-1:0] exp_rdy;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 1'b0;
      m_resv   = 1'b0;
      m_carry  = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      q.delete();
    end else begin
      can = !m_resv || res_ready;
      g   = -1;
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = RR ? (m_ptr + k) % N : k;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      if (!can) g = -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("locked", 64'(locked), 64'(m_locked));
      chk("res_valid", 64'(res_valid), 64'(m_resv));
      if (g >= 0) begin
        cin_m = m_locked ? m_carry : req_cin[g];
        sum_m = {1'b0, req_a[32*g +: 32]} + {1'b0, req_b[32*g +: 32]} + {32'b0, cin_m};
        q.push_back({IDW'(g), sum_m});
        m_ptr = (g + 1) % N;
        if (req_lock[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
          m_carry  = sum_m[32];
        end else begin
          m_locked = 1'b0;
        end
        m_resv = 1'b1;
      end else if (res_ready) begin
        m_resv = 1'b0;
      end
    end
  end

  logic [IDW+32:0] e;
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=id%0d/%0h required=none", res_id, res_sum);
      end else begin
        e = q.pop_front();
        chk("res_id", 64'(res_id), 64'(e[IDW+32:33]));
        chk("res_cout_sum", 64'({res_cout, res_sum}), 64'(e[32:0]));
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic lk, input logic v);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = cin;
    req_lock[i]       = lk;
    req_valid[i]      = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [N-1:0] hs;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_lock = '0;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_sum", 64'(res_sum), 64'd0);
    chk("rst_res_cout", 64'(res_cout), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    rst_n = 1'b1;

    set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
    step();
    set_req(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_sum", 64'(res_sum), 64'h0);
    chk("t1_cout", 64'(res_cout), 64'd1);
    chk("t1_id", 64'(res_id), 64'd0);

    // A req3 transfer brings the round-robin pointer back to 0.
    set_req(3, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    step();
    req_valid = '0;
    chk("t2_pre_id", 64'(res_id), 64'd3);
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'($urandom % 2), 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_seq_id", 64'(res_id), RR ? 64'(k % 4) : 64'd0);
      chk("t2_seq_valid", 64'(res_valid), 64'd1);
    end
    req_valid = '0;
    step();

    set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1);
    step();
    chk("t3_b1_locked", 64'(locked), 64'd1);
    chk("t3_b1", 64'({res_cout, res_sum}), 64'h1_0000_0000);
    chk("t3_b1_id", 64'(res_id), 64'd2);
    set_req(2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    set_req(1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    chk("t3_hold_locked", 64'(locked), 64'd1);
    chk("t3_hold_valid", 64'(res_valid), 64'd0);
    set_req(2, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    chk("t3_b2", 64'({res_cout, res_sum}), 64'h0_0000_0001);
    chk("t3_b2_id", 64'(res_id), 64'd2);
    chk("t3_b2_locked", 64'(locked), 64'd0);
    set_req(2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t6_cin_id", 64'(res_id), 64'd1);
    chk("t6_cin", 64'({res_cout, res_sum}), 64'h0_8000_0000);

    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_bp_ready", 64'(req_ready), 64'd0);
      chk("t4_bp_sum", 64'(res_sum), 64'h8000_0000);
      chk("t4_bp_valid", 64'(res_valid), 64'd1);
    end
    res_ready = 1'b1;
    #1;
    chk("t4_release_ready", 64'(req_ready), 64'b0010);
    step();
    chk("t4_after_valid", 64'(res_valid), 64'd1);
    chk("t4_after_id", 64'(res_id), 64'd1);
    req_valid = '0;
    step();

    set_req(2, $urandom, $urandom, 1'b0, 1'b1, 1'b1);
    step();
    chk("t5_locked", 64'(locked), 64'd1);
    set_req(2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(res_valid), 64'd0);
    chk("t5_rst_sum", 64'(res_sum), 64'd0);
    chk("t5_rst_cout", 64'(res_cout), 64'd0);
    chk("t5_rst_id", 64'(res_id), 64'd0);
    chk("t5_rst_locked", 64'(locked), 64'd0);
    step();
    rst_n = 1'b1;
    set_req(3, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    step();
    req_valid = '0;
    chk("t5_new_id", 64'(res_id), 64'd3);
    chk("t5_new_sum", 64'({res_cout, res_sum}), 64'd11);
    chk("t5_new_locked", 64'(locked), 64'd0);

    // Random traffic: operands only change once accepted or while idle.
    hs = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || hs[i])
          set_req(i, $urandom, $urandom, 1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 3) != 0);
      end
      res_ready = ($urandom % 4) != 0;
    end

    req_valid = '0;
    res_ready = 1'b1;
    repeat (4) step();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
